// File: rtl/func_sel_ctrl.sv
// Function-select front-end: debounces three buttons, stages a 3-bit function code
// and interface select, and commits them atomically to a..d. Optional blink: FUNC_SEL_BLINK_EN.
module func_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 32
`ifdef FUNC_SEL_BLINK_EN
  , parameter int BLINK_CYCLES  = 8
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_swap,
  input  logic       btn_load,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic [2:0] edit_func,
  output logic       edit_dest,
  output logic       editing,
  output logic       commit_pulse,
  output logic       led_pending
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

  // Button vectors are ordered {load, swap, next}.
  logic [2:0]      raw, sync1, sync2, level, press;
  logic [DB_W-1:0] cnt [3];

  assign raw = {btn_load, btn_swap, btn_next};

  // NOTE: every clocked block uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_MAX) begin
          cnt[i]   <= '0;
          level[i] <= sync2[i];
          press[i] <= sync2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Only the highest-priority press of a cycle acts.
  logic act_load, act_swap, act_next;
  assign act_load = press[2];
  assign act_swap = press[1] & ~press[2];
  assign act_next = press[0] & ~press[1] & ~press[2];

  state_t          state, state_nx;
  logic [TO_W-1:0] timer;
  logic [2:0]      func_q;
  logic            dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: defaulting state_nx before the case keeps this block free of latches.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (act_swap || act_next) state_nx = EDIT;
      EDIT: begin
        if (act_load)                                   state_nx = COMMIT;
        else if (!act_swap && !act_next && timer == TO_MAX) state_nx = IDLE;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Staged and committed registers; committed values load on the edge into COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func_q    <= '0;
      dest_q    <= 1'b0;
      edit_func <= '0;
      edit_dest <= 1'b0;
      timer     <= '0;
    end else begin
      case (state)
        IDLE: begin
          edit_func <= act_next ? func_q + 3'd1 : func_q;
          edit_dest <= act_swap ? ~dest_q : dest_q;
          timer     <= '0;
        end
        EDIT: begin
          if (act_load) begin
            func_q <= edit_func;
            dest_q <= edit_dest;
          end else if (act_swap) begin
            edit_dest <= ~edit_dest;
            timer     <= '0;
          end else if (act_next) begin
            edit_func <= edit_func + 3'd1;
            timer     <= '0;
          end else if (timer == TO_MAX) begin
            edit_func <= func_q;
            edit_dest <= dest_q;
            timer     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    editing      = (state == EDIT);
    commit_pulse = (state == COMMIT);
  end

  assign {a, b, c} = func_q;
  assign d         = dest_q;

`ifdef FUNC_SEL_BLINK_EN
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  logic [BL_W-1:0] blink_cnt;
  logic            blink_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (state_nx == EDIT && state != EDIT) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (state_nx == EDIT) begin
      if (blink_cnt == BL_MAX) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end
  end

  assign led_pending = blink_q;
`else
  assign led_pending = editing;
`endif

endmodule

// File: tb/tb_func_sel_ctrl.sv
// Self-checking bench for func_sel_ctrl: directed scenarios plus randomized buttons,
// compared every cycle against a behavioural model of the button/edit/commit rules.
module tb_func_sel_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 32;
  localparam int BLK = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_next = 1'b0, btn_swap = 1'b0, btn_load = 1'b0;
  logic       a, b, c, d;
  logic [2:0] edit_func;
  logic       edit_dest, editing, commit_pulse, led_pending;

  int passed = 0;
  int total  = 0;

  func_sel_ctrl dut (
    .clk(clk), .rst(rst),
    .btn_next(btn_next), .btn_swap(btn_swap), .btn_load(btn_load),
    .a(a), .b(b), .c(c), .d(d),
    .edit_func(edit_func), .edit_dest(edit_dest), .editing(editing),
    .commit_pulse(commit_pulse), .led_pending(led_pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: raw -> two-sample delay -> level accepted after DEB
  // consecutive differing samples; then staged/committed edit rules.
  logic [2:0] m_s1, m_s2, m_db, m_press;
  logic       win [3][DEB];
  logic [2:0] m_cfunc, m_sfunc;
  logic       m_cdest, m_sdest;
  bit         m_edit, m_commit;
  int         m_idle, m_age;
  int         m_commits = 0;
  int         dut_pulses = 0;
  int         div_cycles = 0;
  time        first_div = 0;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < DEB; j++) win[i][j] = 1'b0;
    m_cfunc = '0; m_sfunc = '0; m_cdest = 1'b0; m_sdest = 1'b0;
    m_edit = 0; m_commit = 0; m_idle = 0; m_age = 0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic [2:0] pr, np;
    bit all_diff;
    pr = m_press;
    if (m_commit) begin
      m_commit = 0;
    end else if (m_edit) begin
      m_age++;
      if (pr[2]) begin
        m_cfunc = m_sfunc; m_cdest = m_sdest;
        m_edit = 0; m_commit = 1; m_commits++;
      end else if (pr[1]) begin
        m_sdest = ~m_sdest; m_idle = 0;
      end else if (pr[0]) begin
        m_sfunc = m_sfunc + 3'd1; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          m_edit = 0; m_sfunc = m_cfunc; m_sdest = m_cdest;
        end
      end
    end else if (pr[1] && !pr[2]) begin
      m_sdest = ~m_cdest; m_sfunc = m_cfunc;
      m_edit = 1; m_idle = 0; m_age = 0;
    end else if (pr[0] && !pr[2]) begin
      m_sfunc = m_cfunc + 3'd1; m_sdest = m_cdest;
      m_edit = 1; m_idle = 0; m_age = 0;
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = DEB - 1; j > 0; j--) win[i][j] = win[i][j-1];
      win[i][0] = m_s2[i];
      all_diff = 1;
      for (int j = 0; j < DEB; j++) if (win[i][j] == m_db[i]) all_diff = 0;
      np[i] = 1'b0;
      if (all_diff) begin
        m_db[i] = m_s2[i];
        np[i]   = m_s2[i];
      end
    end
    m_s2 = m_s1; m_s1 = raw; m_press = np;
  endtask

  function automatic logic [10:0] exp_vec();
    logic led;
`ifdef FUNC_SEL_BLINK_EN
    led = m_edit && ((m_age / BLK) % 2 == 0);
`else
    led = m_edit;
`endif
    return {m_cfunc, m_cdest, m_sfunc, m_sdest, m_edit, m_commit, led};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {a, b, c, d, edit_func, edit_dest, editing, commit_pulse, led_pending};
  endfunction

  // One clock: drive buttons, advance the model at the edge, observe at the falling edge.
  task automatic tick(input logic nx, input logic sw, input logic ld);
    btn_next = nx; btn_swap = sw; btn_load = ld;
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge({ld, sw, nx});
    @(negedge clk);
    if (commit_pulse === 1'b1) dut_pulses++;
    if (dut_vec() !== exp_vec()) begin
      if (div_cycles == 0) first_div = $time;
      div_cycles++;
    end
  endtask

  task automatic press_btn(input int which);
    for (int i = 0; i < DEB + 4; i++) tick(which == 0, which == 1, which == 2);
    for (int i = 0; i < DEB + 4; i++) tick(0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) tick(0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    #1;
    total++;
    if (dut_vec() !== 11'b0) $display("FAIL reset_values got %b expected %b", dut_vec(), 11'b0);
    else passed++;
    do_reset();
    repeat (4) tick(0, 0, 0);
    total++;
    if (dut_vec() !== exp_vec()) $display("FAIL reset_idle got %b expected %b", dut_vec(), exp_vec());
    else passed++;
  endtask

  task automatic test_hold_next();
    int p0;
    do_reset();
    p0 = dut_pulses;
    repeat (10) tick(1, 0, 0);
    total++;
    if (edit_func !== 3'd1 || editing !== 1'b1)
      $display("FAIL hold_next_edit got func=%0d editing=%b expected func=1 editing=1", edit_func, editing);
    else passed++;
    repeat (10) tick(0, 0, 0);
    total++;
    if (edit_func !== 3'd1 || {a, b, c, d} !== 4'b0 || dut_pulses != p0)
      $display("FAIL hold_next_single got func=%0d abcd=%b pulses=%0d expected func=1 abcd=0000 pulses=%0d",
               edit_func, {a, b, c, d}, dut_pulses - p0, 0);
    else passed++;
  endtask

  task automatic test_commit_seq();
    int p0;
    do_reset();
    p0 = dut_pulses;
    repeat (3) press_btn(0);
    press_btn(1);
    total++;
    if (edit_func !== 3'd3 || edit_dest !== 1'b1 || {a, b, c, d} !== 4'b0)
      $display("FAIL seq_staged got func=%0d dest=%b abcd=%b expected func=3 dest=1 abcd=0000",
               edit_func, edit_dest, {a, b, c, d});
    else passed++;
    press_btn(2);
    total++;
    if ({a, b, c} !== 3'b011 || d !== 1'b1 || editing !== 1'b0)
      $display("FAIL seq_commit got abc=%b d=%b editing=%b expected abc=011 d=1 editing=0",
               {a, b, c}, d, editing);
    else passed++;
    total++;
    if (dut_pulses - p0 != 1)
      $display("FAIL seq_pulse_count got %0d expected 1", dut_pulses - p0);
    else passed++;
  endtask

  task automatic test_glitch();
    do_reset();
    repeat (2) tick(1, 0, 0);
    repeat (12) tick(0, 0, 0);
    total++;
    if (edit_func !== 3'd0 || editing !== 1'b0)
      $display("FAIL glitch got func=%0d editing=%b expected func=0 editing=0", edit_func, editing);
    else passed++;
  endtask

  task automatic test_timeout();
    int p0;
    do_reset();
    repeat (7) press_btn(0);
    press_btn(2);
    total++;
    if ({a, b, c, d} !== 4'b1110)
      $display("FAIL timeout_setup got abcd=%b expected 1110", {a, b, c, d});
    else passed++;
    p0 = dut_pulses;
    press_btn(0);
    total++;
    if (edit_func !== 3'd0 || editing !== 1'b1)
      $display("FAIL timeout_wrap got func=%0d editing=%b expected func=0 editing=1", edit_func, editing);
    else passed++;
    repeat (TMO) tick(0, 0, 0);
    total++;
    if (edit_func !== 3'd7 || editing !== 1'b0 || dut_pulses != p0 || {a, b, c, d} !== 4'b1110)
      $display("FAIL timeout_abandon got func=%0d editing=%b pulses=%0d abcd=%b expected func=7 editing=0 pulses=0 abcd=1110",
               edit_func, editing, dut_pulses - p0, {a, b, c, d});
    else passed++;
  endtask

  task automatic test_load_and_next();
    do_reset();
    repeat (5) press_btn(0);
    for (int i = 0; i < DEB + 4; i++) tick(1, 0, 1);
    for (int i = 0; i < DEB + 4; i++) tick(0, 0, 0);
    total++;
    if ({a, b, c} !== 3'b101 || edit_func !== 3'd5 || editing !== 1'b0)
      $display("FAIL load_next got abc=%b func=%0d editing=%b expected abc=101 func=5 editing=0",
               {a, b, c}, edit_func, editing);
    else passed++;
  endtask

  task automatic test_reset_mid_edit();
    do_reset();
    press_btn(0);
    tick(0, 1, 0);
    tick(0, 1, 0);
    rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (dut_vec() !== 11'b0) $display("FAIL mid_reset_async got %b expected %b", dut_vec(), 11'b0);
    else passed++;
    @(negedge clk);
    tick(0, 1, 0);
    rst = 1'b0;
    repeat (DEB + 6) tick(0, 1, 0);
    repeat (DEB + 4) tick(0, 0, 0);
    total++;
    if (edit_dest !== 1'b1 || editing !== 1'b1 || {a, b, c, d} !== 4'b0 || edit_func !== 3'd0)
      $display("FAIL mid_reset_swap got dest=%b editing=%b abcd=%b func=%0d expected dest=1 editing=1 abcd=0000 func=0",
               edit_dest, editing, {a, b, c, d}, edit_func);
    else passed++;
    repeat (TMO) tick(0, 0, 0);
    total++;
    if (editing !== 1'b0 || led_pending !== 1'b0 || edit_dest !== 1'b0)
      $display("FAIL mid_reset_timeout got editing=%b led=%b dest=%b expected 0 0 0",
               editing, led_pending, edit_dest);
    else passed++;
  endtask

  task automatic test_random();
    int seg;
    logic nx, sw, ld;
    do_reset();
    for (int n = 0; n < 1500; n += seg) begin
      seg = $urandom_range(1, 12);
      nx  = ($urandom_range(0, 2) == 0);
      sw  = ($urandom_range(0, 4) == 0);
      ld  = ($urandom_range(0, 5) == 0);
      repeat (seg) tick(nx, sw, ld);
    end
    repeat (TMO + 8) tick(0, 0, 0);
    total++;
    if (dut_pulses != m_commits)
      $display("FAIL random_commits got %0d expected %0d", dut_pulses, m_commits);
    else passed++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_hold_next();
    test_commit_seq();
    test_glitch();
    test_timeout();
    test_load_and_next();
    test_reset_mid_edit();
    test_random();
    total++;
    if (div_cycles != 0)
      $display("FAIL cycle_trace got %0d diverging cycles (first at %0t) expected 0", div_cycles, first_div);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/func_sel_ctrl.md
Name: func_sel_ctrl

Overview:
- Sequential front-end that drives the a, b, c, d inputs of the six-bit interface router.
- Turns three raw push-buttons into a committed 3-bit function code {a,b,c} and an interface select d.
- Edits are staged in shadow registers and applied atomically on a load press, so the router never sees intermediate values.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a button level is accepted (>=2).
- TIMEOUT_CYCLES, 32, idle cycles in EDIT before the pending edit is abandoned (>=2).
- BLINK_CYCLES, 8, half-period of led_pending blink; used only with FUNC_SEL_BLINK_EN.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_next  input  1  raw button, active-high: increment staged function code
- btn_swap  input  1  raw button, active-high: toggle staged interface select
- btn_load  input  1  raw button, active-high: commit staged values
- a  output  1  committed function bit 2 (MSB)
- b  output  1  committed function bit 1
- c  output  1  committed function bit 0
- d  output  1  committed interface select, feeds router
- edit_func  output  3  staged function code
- edit_dest  output  1  staged interface select
- editing  output  1  high while FSM in EDIT
- commit_pulse  output  1  one-cycle pulse in the cycle a,b,c,d update
- led_pending  output  1  pending-edit indicator

Behaviour:
- Clock/reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: a, b, c, d = 0; edit_func = 0; edit_dest = 0; editing = 0; commit_pulse = 0; led_pending = 0; FSM = IDLE. Synchronisers, debounce counters, debounced levels, idle timer and blink counter all cleared.
- Input path, per button:
  - 2-flop synchroniser.
  - Counter resets whenever the synced value equals the debounced level, otherwise increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - A press pulse is one cycle on each debounced 0->1 transition.
  - Release produces no pulse.
  - Glitch shorter than DEBOUNCE_CYCLES synced samples produces no pulse.
  - Latency: raw high first sampled at edge k -> press pulse high in the cycle after edge k+1+DEBOUNCE_CYCLES.
- Press arbitration: priority load > swap > next. Only the highest-priority press in a cycle acts; the others are dropped.
- FSM states: IDLE, EDIT, COMMIT.
  - IDLE: edit_func/edit_dest track {a,b,c}/d.
    - next press: edit_func += 1 (mod 8, 7 wraps to 0), go to EDIT.
    - swap press: edit_dest toggles, go to EDIT.
    - load press: ignored, stay IDLE.
  - EDIT: editing = 1. Idle timer clears on entry and on every acted press, otherwise increments.
    - next press: increment (wrap as above).
    - swap press: toggle.
    - load press: go to COMMIT.
    - Timer reaches TIMEOUT_CYCLES-1 with no press: restore edit regs from committed values, go to IDLE.
    - Press and timeout in the same cycle: the press wins.
  - COMMIT (exactly one cycle): a = edit_func[2], b = [1], c = [0], d = edit_dest, all registered. commit_pulse = 1 in this cycle, coincident with the new a..d values. Then go to IDLE.
    - Presses arriving in COMMIT are dropped.
- a..d change only in COMMIT or reset; never glitch otherwise.
- Reset mid-EDIT: the staged edit is lost and outputs return to 0. A button held through reset release yields one press after the debounce latency.

Optional Feature:
- FUNC_SEL_BLINK_EN defined: led_pending toggles every BLINK_CYCLES cycles while in EDIT, starting high on entry; 0 outside EDIT. The blink counter clears on EDIT entry.
- Not defined: led_pending = editing. No blink counter is instantiated.

Test Plan:
- Reset then btn_next held 10 cycles (DEBOUNCE_CYCLES=4) -> one press pulse, edit_func=1, editing=1, a,b,c,d remain 0.
- btn_next pulsed 3 times, btn_swap once, btn_load once -> commit_pulse single cycle, {a,b,c}=011, d=1, editing=0 next cycle.
- btn_next glitch high 2 cycles only -> no press, edit_func stays 0, FSM stays IDLE.
- From committed 111/d=0: btn_next once, then 32 idle cycles (TIMEOUT_CYCLES=32) -> edit_func returns to 7 (wrap to 0 abandoned), editing=0, no commit_pulse.
- btn_load and btn_next debounced in same cycle while in EDIT with edit_func=5 -> COMMIT with {a,b,c}=101, next press dropped.
- rst asserted mid-EDIT with btn_swap held through release -> outputs 0 immediately, one swap press after debounce, edit_dest=1; with FUNC_SEL_BLINK_EN, led_pending toggles every 8 cycles.
